dprs_reader: RTL

- Burst read engine for the read port of the dual-port byte RAM.
- A start command (start address, byte length) makes it issue sequential reads on the RAM read port. It absorbs the RAM's one-cycle registered read latency.
- Delivers the bytes in order on a valid/ready byte stream.
- Used wherever a RAM-resident buffer is drained into a byte consumer, e.g. a sector buffer feeding the FDC data path or a serial sender.

---
 rtl/dprs_reader_if.sv | 26 ++
 rtl/dprs_reader.sv | 109 ++++++++++
 2 files changed

// File: rtl/dprs_reader_if.sv
// Signal bundle for dprs_reader: command strobe, RAM read port and outgoing byte stream.
// The master side is the reader; the slave side is the host, RAM and consumer around it.
interface dprs_reader_if #(
  parameter int AW = 10
);
  logic          start;
  logic [AW-1:0] addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] a;
  logic [7:0]    q;
  logic [7:0]    data;
  logic          valid;
  logic          ready;

  modport master (
    input  start, addr, len, q, ready,
    output busy, done, a, data, valid
  );

  modport slave (
    output start, addr, len, q, ready,
    input  busy, done, a, data, valid
  );
endinterface

// File: rtl/dprs_reader.sv
// Burst read engine: drains len bytes from a registered-read byte RAM starting at addr
// into a valid/ready byte stream through a small FIFO that absorbs the read latency.
module dprs_reader #(
  parameter int KB    = 0,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  dprs_reader_if.master bus
);
  // KB=0 is treated as the smallest (1 KiB) RAM so AW stays meaningful.
  localparam int AW = $clog2(((KB < 1) ? 1 : KB) * 1024);
  localparam int FD = (DEPTH < 4) ? 4 : DEPTH;
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int OW = $clog2(FD + 1);
  localparam logic [OW:0]   FD_L     = (OW + 1)'(FD);
  localparam logic [PW-1:0] LAST_PTR = PW'(FD - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_a;
  logic [AW:0]   r_rem;
  logic          r_ret;
  logic          r_done;
  logic [7:0]    r_fifo [FD];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [OW-1:0] r_occ;

  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_rd;
  logic          w_last;
  logic [OW:0]   w_committed;
  logic [PW-1:0] w_wp_next;
  logic [PW-1:0] w_rp_next;

  assign w_valid     = (r_occ != '0);
  assign w_pop       = w_valid && bus.ready;
  assign w_push      = r_ret;
  // Bytes already in the FIFO plus the read whose data returns this cycle;
  // a same-cycle pop is deliberately ignored so the FIFO can never overflow.
  assign w_committed = {1'b0, r_occ} + (OW + 1)'(r_ret);
  assign w_rd        = (r_state == S_RUN) && (r_rem != '0) && (w_committed < FD_L);
  assign w_last      = (r_state == S_RUN) && (r_rem == '0) && !r_ret &&
                       ((r_occ == '0) || ((r_occ == OW'(1)) && w_pop));
  assign w_wp_next   = (r_wp == LAST_PTR) ? '0 : r_wp + PW'(1);
  assign w_rp_next   = (r_rp == LAST_PTR) ? '0 : r_rp + PW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_rem   <= '0;
      r_ret   <= 1'b0;
      r_done  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_occ   <= '0;
    end else begin
      r_done <= 1'b0;
      r_ret  <= w_rd;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              r_a     <= bus.addr;
              r_rem   <= bus.len;
              r_state <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_rd) begin
            r_a   <= r_a + AW'(1);
            r_rem <= r_rem - (AW + 1)'(1);
          end
          if (w_last) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_push) r_wp <= w_wp_next;
      if (w_pop)  r_rp <= w_rp_next;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage has no reset so it maps onto distributed/block RAM; pointers define contents.
  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wp] <= bus.q;
  end

  assign bus.busy  = (r_state == S_RUN);
  assign bus.done  = r_done;
  assign bus.a     = r_a;
  assign bus.valid = w_valid;
  assign bus.data  = w_valid ? r_fifo[r_rp] : 8'h00;
endmodule
